// File: rtl/pipe_reg_elastic_if.sv
// rtl/pipe_reg_elastic_if.sv - upstream/downstream handshake bundle for the elastic pipeline register
interface pipe_reg_elastic_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 12
);
    logic                  in_valid_i;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic [CTRL_WIDTH-1:0] in_ctrl_i;
    logic                  in_ready_o;
    logic                  out_valid_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic [CTRL_WIDTH-1:0] out_ctrl_o;
    logic                  out_ready_i;

    modport master (
        output in_valid_i, in_data_i, in_ctrl_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_ctrl_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_ctrl_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_ctrl_o
    );
endinterface

// File: rtl/pipe_reg_elastic.sv
// rtl/pipe_reg_elastic.sv - two-entry skid pipeline register with flush and saturating discard counter
module pipe_reg_elastic #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 12,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    pipe_reg_elastic_if.slave    bus,
    output logic [1:0]           occupancy_o,
    output logic [CNT_WIDTH-1:0] discard_cnt_o
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t                state;
    logic                  main_valid;
    logic [DATA_WIDTH-1:0] main_data;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic                  ready;
    logic [CNT_WIDTH-1:0]  discard_cnt;

    logic                  accept;
    logic                  deliver;
    logic [1:0]            held;
    logic [CNT_WIDTH:0]    cnt_sum;

    assign accept  = bus.in_valid_i && ready;
    assign deliver = main_valid && bus.out_ready_i;
    assign held    = {1'b0, main_valid} + {1'b0, skid_valid};
    assign cnt_sum = {1'b0, discard_cnt} + (CNT_WIDTH+1)'(held);

    assign bus.in_ready_o  = ready;
    assign bus.out_valid_o = main_valid;
    assign bus.out_data_o  = main_data;
    assign bus.out_ctrl_o  = main_ctrl;
    assign occupancy_o     = state;
    assign discard_cnt_o   = discard_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= EMPTY;
            main_valid  <= 1'b0;
            main_data   <= '0;
            main_ctrl   <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_ctrl   <= '0;
            ready       <= 1'b1;
            discard_cnt <= '0;
        end else if (flush_i) begin
            // Data fields are left alone; only valid and ctrl must be cleared for a safe bubble.
            state      <= EMPTY;
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            ready      <= 1'b1;
            if (cnt_sum[CNT_WIDTH]) begin
                discard_cnt <= '1;
            end else begin
                discard_cnt <= cnt_sum[CNT_WIDTH-1:0];
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_valid <= 1'b1;
                        main_data  <= bus.in_data_i;
                        main_ctrl  <= bus.in_ctrl_i;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    if (deliver && accept) begin
                        main_data <= bus.in_data_i;
                        main_ctrl <= bus.in_ctrl_i;
                    end else if (deliver) begin
                        main_valid <= 1'b0;
                        main_ctrl  <= '0;
                        state      <= EMPTY;
                    end else if (accept) begin
                        skid_valid <= 1'b1;
                        skid_data  <= bus.in_data_i;
                        skid_ctrl  <= bus.in_ctrl_i;
                        ready      <= 1'b0;
                        state      <= SKID;
                    end
                end
                SKID: begin
                    if (deliver) begin
                        main_data  <= skid_data;
                        main_ctrl  <= skid_ctrl;
                        skid_valid <= 1'b0;
                        skid_ctrl  <= '0;
                        ready      <= 1'b1;
                        state      <= FULL;
                    end
                end
                default: begin
                    state <= EMPTY;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb/tb_pipe_reg_elastic.sv - scoreboard bench for pipe_reg_elastic
module tb_pipe_reg_elastic;
    localparam int DW = 32;
    localparam int CW = 12;
    localparam int NW = 8;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [1:0]    occ;
    logic [NW-1:0] cnt;

    pipe_reg_elastic_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

    pipe_reg_elastic #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .bus          (bus.slave),
        .occupancy_o  (occ),
        .discard_cnt_o(cnt)
    );

    int checks = 0;
    int errors = 0;
    logic [CW+DW-1:0] sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
        return d[CW-1:0] ^ 12'hA5A;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic offer(input logic v, input logic [DW-1:0] d);
        bus.in_valid_i = v;
        bus.in_data_i  = d;
        bus.in_ctrl_i  = ctrl_of(d);
    endtask

    // Record an accept just before the edge that performs it, then settle past the edge.
    task automatic step();
        @(negedge clk);
        if (bus.in_valid_i && bus.in_ready_o && !flush && !rst)
            sb.push_back({bus.in_ctrl_i, bus.in_data_i});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [CW+DW-1:0] exp;
        if (rst || flush) begin
            sb.delete();
        end else if (bus.out_valid_o && bus.out_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_delivery actual=0x%0h expected=none", bus.out_data_o);
            end else begin
                exp = sb.pop_front();
                if ({bus.out_ctrl_o, bus.out_data_o} !== exp) begin
                    errors++;
                    $display("FAIL delivery actual=0x%0h expected=0x%0h",
                             {bus.out_ctrl_o, bus.out_data_o}, exp);
                end
            end
        end
        if (!bus.out_valid_o) chk("bubble_ctrl", 32'(bus.out_ctrl_o), 32'h0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        bus.out_ready_i = 1'b0;
        offer(1'b0, 32'h0);
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'h0);
        chk("rst_out_data", bus.out_data_o, 32'h0);
        chk("rst_out_ctrl", 32'(bus.out_ctrl_o), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'h1);
        chk("rst_occ", 32'(occ), 32'h0);
        chk("rst_cnt", 32'(cnt), 32'h0);
        rst = 1'b0;

        // Streaming at full rate with one-cycle latency
        bus.out_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("stream_in_ready", 32'(bus.in_ready_o), 32'h1);
            offer(1'b1, 32'(i));
            step();
            chk("stream_valid", 32'(bus.out_valid_o), 32'h1);
            chk("stream_data", bus.out_data_o, 32'(i));
        end
        offer(1'b0, 32'h0);
        step();
        chk("stream_drained_occ", 32'(occ), 32'h0);
        chk("stream_sb_empty", 32'(sb.size()), 32'h0);

        // Backpressure fills the skid, then drains in order
        bus.out_ready_i = 1'b0;
        offer(1'b1, 32'hA);
        step();
        offer(1'b1, 32'hB);
        step();
        chk("bp_occ_full", 32'(occ), 32'h2);
        chk("bp_in_ready", 32'(bus.in_ready_o), 32'h0);
        offer(1'b1, 32'hC);
        step();
        chk("bp_hold_occ", 32'(occ), 32'h2);
        chk("bp_stable_data", bus.out_data_o, 32'hA);
        chk("bp_stable_ctrl", 32'(bus.out_ctrl_o), 32'(ctrl_of(32'hA)));
        bus.out_ready_i = 1'b1;
        step();
        chk("bp_ready_back", 32'(bus.in_ready_o), 32'h1);
        chk("bp_second_out", bus.out_data_o, 32'hB);
        step();
        offer(1'b0, 32'h0);
        chk("bp_third_out", bus.out_data_o, 32'hC);
        step();
        step();
        chk("bp_sb_empty", 32'(sb.size()), 32'h0);

        // Flush while in SKID with a simultaneous offer and ready
        bus.out_ready_i = 1'b0;
        offer(1'b1, 32'h11);
        step();
        offer(1'b1, 32'h12);
        step();
        chk("fl_pre_occ", 32'(occ), 32'h2);
        bus.out_ready_i = 1'b1;
        offer(1'b1, 32'hD);
        flush = 1'b1;
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0);
        chk("fl_out_valid", 32'(bus.out_valid_o), 32'h0);
        chk("fl_out_ctrl", 32'(bus.out_ctrl_o), 32'h0);
        chk("fl_occ", 32'(occ), 32'h0);
        chk("fl_cnt", 32'(cnt), 32'h2);
        chk("fl_in_ready", 32'(bus.in_ready_o), 32'h1);
        step();
        step();

        // Saturation of the discard counter
        bus.out_ready_i = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            offer(1'b1, 32'(i));
            step();
            offer(1'b0, 32'h0);
            flush = 1'b1;
            step();
            flush = 1'b0;
            if (i == 100) chk("sat_mid_cnt", 32'(cnt), 32'd102);
        end
        chk("sat_cnt", 32'(cnt), 32'hFF);
        offer(1'b1, 32'h77);
        step();
        offer(1'b0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sat_hold", 32'(cnt), 32'hFF);

        // Reset wins over flush while in SKID
        offer(1'b1, 32'h21);
        step();
        offer(1'b1, 32'h22);
        step();
        chk("rs_pre_occ", 32'(occ), 32'h2);
        offer(1'b1, 32'h23);
        rst   = 1'b1;
        flush = 1'b1;
        step();
        rst   = 1'b0;
        flush = 1'b0;
        chk("rs_out_valid", 32'(bus.out_valid_o), 32'h0);
        chk("rs_out_data", bus.out_data_o, 32'h0);
        chk("rs_out_ctrl", 32'(bus.out_ctrl_o), 32'h0);
        chk("rs_in_ready", 32'(bus.in_ready_o), 32'h1);
        chk("rs_occ", 32'(occ), 32'h0);
        chk("rs_cnt", 32'(cnt), 32'h0);
        offer(1'b1, 32'h5);
        step();
        offer(1'b0, 32'h0);
        chk("rs_first_valid", 32'(bus.out_valid_o), 32'h1);
        chk("rs_first_data", bus.out_data_o, 32'h5);
        chk("rs_first_ctrl", 32'(bus.out_ctrl_o), 32'(ctrl_of(32'h5)));
        bus.out_ready_i = 1'b1;
        step();
        step();
        chk("end_sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
